// File: rtl/goal_hit_detector.sv
// rtl/goal_hit_detector.sv - classifies a ball sighting against the goal mouth over one armed frame
//
// Purpose:
//   Watches the final drawn pixel stream. After an arm request it waits for the
//   next frame start, counts key-coloured pixels inside and outside the goal
//   window over one full frame, then holds a verdict until it is acknowledged.
//
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   hcount       horizontal pixel position (11 bits)
//   vcount       vertical pixel position (11 bits)
//   hblnk        horizontal blanking flag
//   vblnk        vertical blanking flag
//   rgb          drawn pixel colour (12 bits)
//   arm          single-cycle request to analyse the next full frame
//   result_ack   consumer acknowledge of the held verdict
//   result_valid verdict is held
//   result       00 none, 01 goal, 10 miss, 11 partial
//   busy         waiting for frame start or counting

module goal_hit_detector #(
    parameter logic [11:0] KEY_RGB    = 12'hF_8_0,
    parameter int          GOAL_X_MIN = 155,
    parameter int          GOAL_X_MAX = 868,
    parameter int          GOAL_Y_MIN = 200,
    parameter int          GOAL_Y_MAX = 549,
    parameter int          MIN_PIXELS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        hblnk,
    input  logic        vblnk,
    input  logic [11:0] rgb,
    input  logic        arm,
    input  logic        result_ack,
    output logic        result_valid,
    output logic [1:0]  result,
    output logic        busy
);

    localparam logic [10:0] X_MIN   = GOAL_X_MIN[10:0];
    localparam logic [10:0] X_MAX   = GOAL_X_MAX[10:0];
    localparam logic [10:0] Y_MIN   = GOAL_Y_MIN[10:0];
    localparam logic [10:0] Y_MAX   = GOAL_Y_MAX[10:0];
    localparam logic [19:0] MIN_CNT = MIN_PIXELS[19:0];
    localparam logic [19:0] CNT_MAX = 20'hFFFFF;

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_GOAL    = 2'b01;
    localparam logic [1:0] RES_MISS    = 2'b10;
    localparam logic [1:0] RES_PARTIAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        COUNT  = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t      state;
    logic        vblnk_q;
    logic [19:0] in_cnt;
    logic [19:0] out_cnt;

    logic        vblnk_fall;
    logic        vblnk_rise;
    logic        key_px;
    logic        in_goal;
    logic [1:0]  verdict;

    assign vblnk_fall = vblnk_q & ~vblnk;
    assign vblnk_rise = ~vblnk_q & vblnk;
    // Blanked pixels are never part of the picture, even if rgb happens to match.
    assign key_px     = ~hblnk & ~vblnk & (rgb == KEY_RGB);
    assign in_goal    = (hcount >= X_MIN) && (hcount <= X_MAX) &&
                        (vcount >= Y_MIN) && (vcount <= Y_MAX);

    always_comb begin
        verdict = RES_NONE;
        if (in_cnt >= MIN_CNT) begin
            verdict = (out_cnt == 20'd0) ? RES_GOAL : RES_PARTIAL;
        end else if (out_cnt != 20'd0) begin
            verdict = RES_MISS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            vblnk_q      <= 1'b0;
            in_cnt       <= 20'd0;
            out_cnt      <= 20'd0;
            result_valid <= 1'b0;
            result       <= RES_NONE;
            busy         <= 1'b0;
        end else begin
            vblnk_q <= vblnk;
            case (state)
                IDLE: begin
                    if (arm) begin
                        state   <= SYNC;
                        busy    <= 1'b1;
                        in_cnt  <= 20'd0;
                        out_cnt <= 20'd0;
                    end
                end
                SYNC: begin
                    // Only a falling vblnk marks a frame start; an arm that lands
                    // mid-frame therefore skips the rest of that frame.
                    if (vblnk_fall) begin
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (vblnk_rise) begin
                        state        <= REPORT;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        result       <= verdict;
                    end else if (key_px) begin
                        if (in_goal) begin
                            if (in_cnt != CNT_MAX) in_cnt <= in_cnt + 20'd1;
                        end else begin
                            if (out_cnt != CNT_MAX) out_cnt <= out_cnt + 20'd1;
                        end
                    end
                end
                REPORT: begin
                    if (result_ack) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                        result       <= RES_NONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_goal_hit_detector.sv
// tb/tb_goal_hit_detector.sv - directed self-checking bench for goal_hit_detector

module tb_goal_hit_detector;

    localparam logic [11:0] KEY = 12'hF80;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
    logic        arm;
    logic        result_ack;
    logic        result_valid;
    logic [1:0]  result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    goal_hit_detector dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hcount       (hcount),
        .vcount       (vcount),
        .hblnk        (hblnk),
        .vblnk        (vblnk),
        .rgb          (rgb),
        .arm          (arm),
        .result_ack   (result_ack),
        .result_valid (result_valid),
        .result       (result),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Four vblank cycles, then a small active window around a w x h key
    // rectangle at (sx,sy) with two hblank cycles per line. Ends with vblnk
    // driven high but not yet clocked, so the caller sees the rise edge.
    task automatic run_frame(input int sx, input int sy, input int w, input int h,
                             input bit key_blank, input int arm_at);
        int idx;
        idx = 0;
        hblnk = 1'b1; vblnk = 1'b1; hcount = 11'd500; vcount = 11'd300;
        rgb = key_blank ? KEY : 12'h000;
        repeat (4) tick();
        for (int v = sy - 2; v < sy + h + 2; v++) begin
            for (int x = sx - 2; x < sx + w + 2; x++) begin
                hblnk = 1'b0; vblnk = 1'b0;
                hcount = x[10:0]; vcount = v[10:0];
                rgb = (x >= sx && x < sx + w && v >= sy && v < sy + h) ? KEY : 12'h000;
                arm = (idx == arm_at);
                idx++;
                tick();
            end
            arm = 1'b0; hblnk = 1'b1; hcount = 11'd500; vcount = v[10:0];
            rgb = key_blank ? KEY : 12'h000;
            repeat (2) tick();
        end
        arm = 1'b0; hblnk = 1'b1; vblnk = 1'b1; rgb = 12'h000;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL arm_busy got %b expected 1", busy); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; arm = 1'b0; result_ack = 1'b0;
        hblnk = 1'b1; vblnk = 1'b1; hcount = 11'd0; vcount = 11'd0; rgb = 12'h000;
        repeat (3) tick();
        checks++;
        if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", result_valid); end
        checks++;
        if (result !== 2'b00) begin errors++; $display("FAIL reset_result got %b expected 00", result); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        rst_n = 1'b1;
        tick();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_ack got valid=%b busy=%b expected 0 0", result_valid, busy);
        end
    endtask

    task automatic test_goal();
        do_arm();
        run_frame(500, 300, 8, 8, 1'b0, -1);
        checks++;
        if (result_valid !== 1'b0) begin errors++; $display("FAIL goal_pre_edge got %b expected 0", result_valid); end
        tick();
        checks++;
        if (result_valid !== 1'b1) begin errors++; $display("FAIL goal_valid got %b expected 1", result_valid); end
        checks++;
        if (result !== 2'b01) begin errors++; $display("FAIL goal_result got %b expected 01", result); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL goal_busy got %b expected 0", busy); end
        repeat (3) tick();
        checks++;
        if (result_valid !== 1'b1 || result !== 2'b01) begin
            errors++; $display("FAIL goal_hold got valid=%b result=%b expected 1 01", result_valid, result);
        end
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || result !== 2'b00) begin
            errors++; $display("FAIL goal_ack got valid=%b result=%b expected 0 00", result_valid, result);
        end
    endtask

    task automatic test_miss();
        do_arm();
        run_frame(100, 300, 8, 8, 1'b0, -1);
        tick();
        checks++;
        if (result_valid !== 1'b1 || result !== 2'b10) begin
            errors++; $display("FAIL miss_result got valid=%b result=%b expected 1 10", result_valid, result);
        end
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
    endtask

    task automatic test_partial_and_rearm();
        do_arm();
        run_frame(864, 300, 8, 8, 1'b0, -1);
        tick();
        checks++;
        if (result_valid !== 1'b1 || result !== 2'b11) begin
            errors++; $display("FAIL partial_result got valid=%b result=%b expected 1 11", result_valid, result);
        end
        arm = 1'b1; result_ack = 1'b1;
        tick();
        arm = 1'b0; result_ack = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL ack_with_arm got valid=%b busy=%b expected 0 0", result_valid, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL arm_ignored_busy got %b expected 0", busy); end
    endtask

    task automatic test_threshold();
        do_arm();
        run_frame(500, 300, 5, 3, 1'b1, -1);
        tick();
        checks++;
        if (result_valid !== 1'b1 || result !== 2'b00) begin
            errors++; $display("FAIL thresh15_result got valid=%b result=%b expected 1 00", result_valid, result);
        end
        result_ack = 1'b1; tick(); result_ack = 1'b0;
        do_arm();
        run_frame(500, 300, 4, 4, 1'b0, -1);
        tick();
        checks++;
        if (result_valid !== 1'b1 || result !== 2'b01) begin
            errors++; $display("FAIL thresh16_result got valid=%b result=%b expected 1 01", result_valid, result);
        end
        result_ack = 1'b1; tick(); result_ack = 1'b0;
    endtask

    task automatic test_arm_midframe();
        run_frame(100, 300, 8, 8, 1'b0, 30);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy got %b expected 1", busy); end
        tick();
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL midframe_no_result got valid=%b busy=%b expected 0 1", result_valid, busy);
        end
        run_frame(500, 300, 8, 8, 1'b0, -1);
        tick();
        checks++;
        if (result_valid !== 1'b1 || result !== 2'b01) begin
            errors++; $display("FAIL midframe_next_result got valid=%b result=%b expected 1 01", result_valid, result);
        end
        result_ack = 1'b1; tick(); result_ack = 1'b0;
    endtask

    task automatic test_reset_midcount();
        do_arm();
        hblnk = 1'b1; vblnk = 1'b1; rgb = 12'h000;
        repeat (4) tick();
        for (int i = 0; i < 20; i++) begin
            hblnk = 1'b0; vblnk = 1'b0; hcount = 11'(500 + i); vcount = 11'd300; rgb = KEY;
            tick();
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL count_busy got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 2'b00) begin
            errors++; $display("FAIL async_reset got busy=%b valid=%b result=%b expected 0 0 00", busy, result_valid, result);
        end
        tick(); tick();
        rst_n = 1'b1;
        run_frame(500, 300, 8, 8, 1'b0, -1);
        tick();
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle got valid=%b busy=%b expected 0 0", result_valid, busy);
        end
        repeat (3) tick();
        checks++;
        if (result_valid !== 1'b0) begin errors++; $display("FAIL post_reset_hold got %b expected 0", result_valid); end
    endtask

    initial begin
        test_reset();
        test_goal();
        test_miss();
        test_partial_and_rearm();
        test_threshold();
        test_arm_midframe();
        test_reset_midcount();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
